// File: rtl/bch_chien_search_pkg.sv
// Shared types, field constants and GF(16) arithmetic for the BCH(15,7) Chien search.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bch_pkg;

   typedef logic [3:0]  gf_t;
   typedef logic [14:0] cw_t;

   localparam int unsigned N = 15;
   localparam int unsigned M = 4;

   // x^4 + x + 1
   localparam logic [4:0] GF_POLY    = 5'b10011;
   // alpha^-1 = alpha^14, alpha^-2 = alpha^13
   localparam gf_t        ALPHA_INV  = 4'b1001;
   localparam gf_t        ALPHA_INV2 = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Shift-and-add multiply in GF(16); reduces by GF_POLY after every shift.
   function automatic gf_t gf_mul(gf_t a, gf_t b);
      gf_t acc;
      gf_t x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[3] ? ({x[2:0], 1'b0} ^ GF_POLY[3:0]) : {x[2:0], 1'b0};
      end
      return acc;
   endfunction

endpackage

// File: rtl/bch_chien_search_if.sv
// Request/result bundle between the Berlekamp-Massey stage and the Chien search.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the search is not busy.
interface bch_chien_search_if;
   import bch_pkg::*;

   logic start;
   gf_t  lambda1;
   gf_t  lambda2;
   cw_t  rx_word;
   logic busy;
   logic done;
   cw_t  corrected;
   cw_t  err_pos;
   logic [1:0] err_count;
   logic fail;

   modport master (
      output start, lambda1, lambda2, rx_word,
      input  busy, done, corrected, err_pos, err_count, fail
   );

   modport slave (
      input  start, lambda1, lambda2, rx_word,
      output busy, done, corrected, err_pos, err_count, fail
   );
endinterface

// File: rtl/bch_chien_search_gf16_mul_const.sv
// Multiply a GF(16) element by a fixed constant; pure XOR network.
// Latency: combinational.
// Backpressure: none.
module gf16_mul_const
   import bch_pkg::*;
#(
   parameter gf_t K = 4'b0001
) (
   input  gf_t a,
   output gf_t y
);

   // Constant operand folds the multiply down to a handful of XORs.
   always_comb begin
      y = gf_mul(a, K);
   end

endmodule

// File: rtl/bch_chien_search.sv
// Serial Chien search for BCH(15,7) t=2: tests one codeword position per cycle.
// Latency: start sampled at edge 0, results and done pulse register at edge 16.
// Backpressure: start ignored during EVAL; accepted in IDLE and in FIN (back-to-back).
module bch_chien_search
   import bch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   bch_chien_search_if.slave  bus
);

   state_t     state_q, state_d;
   logic [3:0] j_q, j_d;
   gf_t        r1_q, r1_d;
   gf_t        r2_q, r2_d;
   cw_t        mask_q, mask_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] deg_q, deg_d;
   cw_t        rx_q, rx_d;
   logic       done_q, done_d;
   cw_t        corrected_q, corrected_d;
   cw_t        err_pos_q, err_pos_d;
   logic [1:0] err_count_q, err_count_d;
   logic       fail_q, fail_d;

   gf_t  r1_step;
   gf_t  r2_step;
   logic root;
   logic load;
   logic fail_now;

   gf16_mul_const #(.K(ALPHA_INV))  u_mul_r1 (.a(r1_q), .y(r1_step));
   gf16_mul_const #(.K(ALPHA_INV2)) u_mul_r2 (.a(r2_q), .y(r2_step));

   // Next-state, search datapath and result capture.
   always_comb begin
      state_d     = state_q;
      j_d         = j_q;
      r1_d        = r1_q;
      r2_d        = r2_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      deg_d       = deg_q;
      rx_d        = rx_q;
      done_d      = 1'b0;
      corrected_d = corrected_q;
      err_pos_d   = err_pos_q;
      err_count_d = err_count_q;
      fail_d      = fail_q;

      // lambda(alpha^-j) = 1 + r1 + r2 with r1, r2 already scaled for position j
      root     = ((4'b0001 ^ r1_q ^ r2_q) == 4'b0000);
      load     = bus.start && (state_q == IDLE || state_q == FIN);
      fail_now = (cnt_q != deg_q);

      case (state_q)
         IDLE: ;
         EVAL: begin
            r1_d = r1_step;
            r2_d = r2_step;
            if (root) begin
               mask_d = mask_q | (cw_t'(1) << j_q);
               cnt_d  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            end
            if (j_q == 4'(N - 1)) begin
               state_d = FIN;
            end else begin
               j_d = j_q + 4'd1;
            end
         end
         FIN: begin
            done_d      = 1'b1;
            err_pos_d   = mask_q;
            err_count_d = cnt_q;
            fail_d      = fail_now;
            // An uncorrectable word is passed through untouched.
            corrected_d = fail_now ? rx_q : (rx_q ^ mask_q);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Capture a new request; in FIN this overrides the return to IDLE.
      if (load) begin
         state_d = EVAL;
         j_d     = 4'd0;
         r1_d    = bus.lambda1;
         r2_d    = bus.lambda2;
         rx_d    = bus.rx_word;
         mask_d  = '0;
         cnt_d   = 2'd0;
         if (bus.lambda2 != 4'd0)      deg_d = 2'd2;
         else if (bus.lambda1 != 4'd0) deg_d = 2'd1;
         else                          deg_d = 2'd0;
      end
   end

   // State and result registers; reset aborts any search in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         j_q         <= 4'd0;
         r1_q        <= '0;
         r2_q        <= '0;
         mask_q      <= '0;
         cnt_q       <= 2'd0;
         deg_q       <= 2'd0;
         rx_q        <= '0;
         done_q      <= 1'b0;
         corrected_q <= '0;
         err_pos_q   <= '0;
         err_count_q <= 2'd0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         j_q         <= j_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         deg_q       <= deg_d;
         rx_q        <= rx_d;
         done_q      <= done_d;
         corrected_q <= corrected_d;
         err_pos_q   <= err_pos_d;
         err_count_q <= err_count_d;
         fail_q      <= fail_d;
      end
   end

   // Drive the interface outputs straight from flops.
   always_comb begin
      bus.busy      = (state_q == EVAL);
      bus.done      = done_q;
      bus.corrected = corrected_q;
      bus.err_pos   = err_pos_q;
      bus.err_count = err_count_q;
      bus.fail      = fail_q;
   end

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for the BCH(15,7) Chien search with hand-computed expectations.
module tb_bch_chien_search;
   import bch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   lat;
   logic seen_done;

   bch_chien_search_if bif ();

   bch_chien_search dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request and let edge 0 sample it.
   task automatic do_start(input gf_t l1, input gf_t l2, input cw_t rx);
      bif.lambda1 = l1;
      bif.lambda2 = l2;
      bif.rx_word = rx;
      bif.start   = 1'b1;
      tick();
      bif.start   = 1'b0;
   endtask

   // Cycles from the start-sampling edge to done, bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!bif.done && cycles < 40);
   endtask

   task automatic chk_res(input string tag, input cw_t pos, input cw_t cor,
                          input logic [1:0] cnt, input logic f);
      chk({tag, "_err_pos"},   32'(bif.err_pos),   32'(pos));
      chk({tag, "_corrected"}, 32'(bif.corrected), 32'(cor));
      chk({tag, "_err_count"}, 32'(bif.err_count), 32'(cnt));
      chk({tag, "_fail"},      32'(bif.fail),      32'(f));
   endtask

   initial begin
      bif.start   = 1'b0;
      bif.lambda1 = '0;
      bif.lambda2 = '0;
      bif.rx_word = '0;

      // Reset state
      tick(); tick(); tick();
      chk("rst_busy", 32'(bif.busy), 32'd0);
      chk("rst_done", 32'(bif.done), 32'd0);
      chk_res("rst", 15'h0000, 15'h0000, 2'd0, 1'b0);
      rst = 1'b0;
      tick();

      // Case 1 (errors at 7 and 3) with case 2 queued back-to-back in FIN
      do_start(4'b0011, 4'b0111, 15'h0088);
      chk("c1_busy", 32'(bif.busy), 32'd1);
      for (int i = 0; i < 15; i++) tick();
      chk("c1_fin_busy", 32'(bif.busy), 32'd0);
      chk("c1_fin_done_early", 32'(bif.done), 32'd0);
      bif.lambda1 = 4'b0110;
      bif.lambda2 = 4'b0000;
      bif.rx_word = 15'h0020;
      bif.start   = 1'b1;
      tick();
      bif.start   = 1'b0;
      chk("c1_done", 32'(bif.done), 32'd1);
      chk("b2b_busy", 32'(bif.busy), 32'd1);
      chk_res("c1", 15'h0088, 15'h0000, 2'd2, 1'b0);
      wait_done(lat);
      chk("c2_latency", 32'(lat), 32'd16);
      chk_res("c2", 15'h0020, 15'h0000, 2'd1, 1'b0);
      tick();
      chk("c2_done_pulse", 32'(bif.done), 32'd0);
      chk_res("c2_hold", 15'h0020, 15'h0000, 2'd1, 1'b0);

      // Case 4: uncorrectable (one root, degree 2)
      do_start(4'b0000, 4'b0001, 15'h7FFF);
      wait_done(lat);
      chk("c4_latency", 32'(lat), 32'd16);
      chk_res("c4", 15'h0001, 15'h7FFF, 2'd1, 1'b1);

      // Case 6: inputs change and start pulses during EVAL; case 1 results expected
      tick();
      do_start(4'b0011, 4'b0111, 15'h0088);
      bif.lambda1 = 4'b0000;
      bif.lambda2 = 4'b0001;
      bif.rx_word = 15'h7FFF;
      tick(); tick(); tick(); tick();
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      lat = 5;
      while (!bif.done && lat < 40) begin
         tick();
         lat++;
      end
      chk("c6_latency", 32'(lat), 32'd16);
      chk_res("c6", 15'h0088, 15'h0000, 2'd2, 1'b0);

      // Abort: reset in cycle 8 of EVAL
      tick();
      do_start(4'b0110, 4'b0000, 15'h0020);
      for (int i = 0; i < 7; i++) tick();
      chk("abort_busy_before", 32'(bif.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(bif.busy), 32'd0);
      chk("abort_done", 32'(bif.done), 32'd0);
      chk_res("abort", 15'h0000, 15'h0000, 2'd0, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bif.done) seen_done = 1'b1;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);

      // Case 3: zero locator after the abort
      do_start(4'b0000, 4'b0000, 15'h1234);
      wait_done(lat);
      chk("c3_latency", 32'(lat), 32'd16);
      chk_res("c3", 15'h0000, 15'h1234, 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bch_chien_search.md
Name: bch_chien_search

Overview:
Downstream stage of the BCH(15,7), t=2 decoder over GF(16), primitive polynomial x^4+x+1. Consumes the error-locator coefficients lambda1/lambda2 from the Berlekamp-Massey stage, together with the received 15-bit word. It runs a serial Chien search, one codeword position per cycle, and emits the corrected word, the error mask, the error count and an uncorrectable flag.

Parameters:
N, 15, codeword length; fixed for this code and used as the loop bound.
M, 4, GF field width in bits.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
lambda1  in  4  locator coefficient of x^1; bit 3 = alpha^3 coefficient
lambda2  in  4  locator coefficient of x^2
rx_word  in  15  received word; bit j = coefficient of x^j
busy  out  1  high while evaluating
done  out  1  one-cycle pulse when results update
corrected  out  15  rx_word XOR err_pos; equals rx_word when fail=1
err_pos  out  15  bit j set when lambda(alpha^-j)=0
err_count  out  2  number of roots found, saturates at 3
fail  out  1  root count != degree of lambda

Behaviour:
- Reset: state IDLE; busy, done, fail, err_count, err_pos and corrected all 0. Reset mid-search aborts it with no done pulse.
- States:
  - IDLE: on start, latch lambda1, lambda2 and rx_word, then go to EVAL with j=0.
  - EVAL: j counts 0..14.
  - FIN: one cycle, done=1, then IDLE.
- Capture: start=1 in IDLE or FIN is accepted. FIN->EVAL is back-to-back with no bubble. start while in EVAL is ignored.
- EVAL datapath:
  - Registers r1 and r2 load lambda1 and lambda2 at start.
  - Each cycle: r1 <= r1*alpha^-1 (alpha^14=4'b1001), r2 <= r2*alpha^-2 (alpha^13=4'b1101). Both are constant GF multiplies.
  - Root test: (4'b0001 ^ r1 ^ r2) == 0 sets mask bit j and increments the root counter, which saturates at 3.
- Latency: start sampled at edge 0; EVAL spans edges 1..15; outputs register at edge 16 together with done=1.
- Output hold: outputs stay stable until the next FIN. busy=1 exactly during EVAL.
- Degree of lambda: 2 if lambda2!=0; 1 if lambda2==0 and lambda1!=0; 0 if both are 0.
- fail = (roots != degree). On fail: corrected=rx_word, err_pos=mask as found, err_count=roots.
- Zero locator (lambda1=lambda2=0): no roots, fail=0, corrected=rx_word.
- Input stability: inputs only matter in the start cycle; later input changes have no effect.

Decomposition:
- Package bch_pkg holds:
  - gf_t (logic [3:0]) and cw_t (logic [14:0]).
  - GF_POLY=5'b10011.
  - ALPHA_INV=4'b1001 and ALPHA_INV2=4'b1101.
  - state enum {IDLE, EVAL, FIN}.
- One sub-module, gf16_mul_const, parameterised by the constant operand and instantiated twice.

Test Plan:
1. Two errors at bits 7 and 3: lambda1=4'b0011, lambda2=4'b0111, rx_word=15'h0088, start pulse -> done exactly 16 cycles later; err_pos=15'h0088, corrected=15'h0000, err_count=2, fail=0.
2. Single error at bit 5: lambda1=4'b0110, lambda2=0, rx_word=15'h0020 -> err_pos=15'h0020, corrected=0, err_count=1, fail=0.
3. No error: lambda1=lambda2=0, rx_word=15'h1234 -> corrected=15'h1234, err_pos=0, err_count=0, fail=0.
4. Uncorrectable: lambda1=0, lambda2=4'b0001, rx_word=15'h7FFF -> err_pos=15'h0001, err_count=1, fail=1, corrected=15'h7FFF.
5. Back-to-back and abort:
   - Raise start again in the FIN cycle of case 1, with case 2 inputs -> second done 16 cycles later with case 2 results.
   - start during EVAL is ignored.
   - rst at cycle 8 of EVAL -> busy=0 next cycle, outputs 0, no done.
6. Input stability: change lambda and rx_word during EVAL of case 1 -> results still match case 1.
